// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to unsigned binary converter.
// Uses reverse double-dabble with one shift per clock and
// valid/ready handshakes on both sides. A word with any digit above 9
// skips conversion and is reported with out_err=1 and out_bin=0.
`timescale 1ns/1ps

module bcd_to_bin_seq #(
    parameter  int N_DIGIT = 4,
    localparam int BW      = $clog2(10**N_DIGIT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*N_DIGIT-1:0] in_bcd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW-1:0]        out_bin,
    output logic                 out_err
);

    localparam int DW = 4 * N_DIGIT;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   bcd_r;
    logic [BW-1:0]   bin_r;
    logic [CW-1:0]   cnt;
    logic            err_r;

    logic [DW-1:0]   bcd_shift;
    logic [DW-1:0]   bcd_next;
    logic [BW-1:0]   bin_next;
    logic            in_illegal;

    // One reverse double-dabble step: shift right, then pull each digit >= 8 down by 3.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bcd_shift = {1'b0, bcd_r[DW-1:1]};
        bcd_next  = bcd_shift;
        bin_next  = {bcd_r[0], bin_r[BW-1:1]};
        for (int i = 0; i < N_DIGIT; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8) begin
                bcd_next[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    // Flag an incoming word that holds any non-decimal digit.
    always_comb begin
        in_illegal = 1'b0;
        for (int i = 0; i < N_DIGIT; i++) begin
            if (in_bcd[4*i +: 4] > 4'd9) begin
                in_illegal = 1'b1;
            end
        end
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt       <= '0;
            err_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_r    <= in_bcd;
                        bin_r    <= '0;
                        in_ready <= 1'b0;
                        if (in_illegal) begin
                            // Bad digit: report immediately, no conversion.
                            err_r     <= 1'b1;
                            out_bin   <= '0;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err_r <= 1'b0;
                            cnt   <= CW'(BW);
                            state <= CONV;
                        end
                    end
                end

                CONV: begin
                    bcd_r <= bcd_next;
                    bin_r <= bin_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Last shift: publish the freshly shifted binary word.
                        out_bin   <= bin_next;
                        out_err   <= err_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and randomized checks of bcd_to_bin_seq
// (N_DIGIT=4) against a decimal arithmetic reference model.
`timescale 1ns/1ps

module tb_bcd_to_bin_seq;

    localparam int N_DIGIT = 4;
    localparam int BW      = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_bcd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_bin;
    logic          out_err;

    int n_checks = 0;
    int n_fail   = 0;
    int last_val = 0;
    bit last_err = 1'b0;

    bcd_to_bin_seq #(.N_DIGIT(N_DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain decimal weighting of the digits; any digit above 9 is an error.
    function automatic void ref_model(input logic [15:0] w, output int val, output bit err);
        val = 0;
        err = 1'b0;
        for (int i = N_DIGIT - 1; i >= 0; i--) begin
            int d;
            d = int'(w[4*i +: 4]);
            if (d > 9) err = 1'b1;
            val = val * 10 + d;
        end
        if (err) val = 0;
    endfunction

    // Offer one word, then wait for and check the result and its latency.
    task automatic send_and_check(input logic [15:0] w);
        int exp_val;
        bit exp_err;
        int c;
        ref_model(w, exp_val, exp_err);
        c = 0;
        while (!in_ready && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_bcd   = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
        check("in_ready_after_accept", in_ready, 0);
        c = 1;
        while (!out_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("latency", c, exp_err ? 1 : BW + 1);
        check("out_bin", out_bin, exp_val);
        check("out_err", out_err, exp_err);
        if (!exp_err) check("bcd_r_zero_at_done", dut.bcd_r, 0);
        last_val = exp_val;
        last_err = exp_err;
    endtask

    // Hold out_ready low for 'hold' cycles (optionally with in_valid noise), then consume.
    task automatic consume(input int hold, input bit noise);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                in_bcd   = 16'($urandom);
            end
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_bin", out_bin, last_val);
            check("hold_out_err", out_err, last_err);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_out_valid", out_valid, 0);
        check("consumed_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_err", out_err, 0);
        check("rst_cnt", dut.cnt, 0);
        check("rst_bcd_r", dut.bcd_r, 0);
        check("rst_bin_r", dut.bin_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed words, including all-nines, zero and an illegal digit.
        send_and_check(16'h1234);
        consume(0, 1'b0);
        send_and_check(16'h9999);
        consume(0, 1'b0);
        send_and_check(16'h0000);
        consume(0, 1'b0);
        send_and_check(16'h12A4);
        consume(2, 1'b0);
        send_and_check(16'hF000);
        consume(1, 1'b0);

        // Backpressure with ignored in_valid pulses; next word accepted at R+1.
        send_and_check(16'h0500);
        consume(20, 1'b1);
        send_and_check(16'h0777);

        // Reset during conversion after 7 iterations.
        consume(0, 1'b0);
        in_valid = 1'b1;
        in_bcd   = 16'h4321;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_conv_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_bin", out_bin, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_cnt", dut.cnt, 0);
        check("mid_rst_bcd_r", dut.bcd_r, 0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_and_check(16'h0042);
        consume(0, 1'b0);

        // Random legal words with random downstream backpressure.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] w;
            for (int i = 0; i < N_DIGIT; i++) begin
                w[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            send_and_check(w);
            consume(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
